// File: rtl/ddr_memory_pkg.sv
// Shared types and default sizing for the ddr_memory model.
package ddr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MEM_SIZE   = 16;

endpackage

// File: rtl/ddr_memory_if.sv
// Command/response bundle between a stimulus master and the ddr_memory slave.
interface ddr_memory_if #(
  parameter int unsigned ADDR_WIDTH = ddr_mem_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ddr_mem_pkg::DEF_DATA_WIDTH
) ();

  logic                  reset;
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  slv_rsp;

  modport master (
    output reset, wr, rd, addr, wdata,
    input  rdata, slv_rsp
  );

  modport slave (
    input  reset, wr, rd, addr, wdata,
    output rdata, slv_rsp
  );

endinterface

// File: rtl/ddr_memory.sv
// Single-port word memory: a command is captured in IDLE and completes one
// cycle later with a registered one-cycle response pulse.
module ddr_memory
  import ddr_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MEM_SIZE   = DEF_MEM_SIZE
) (
  input logic         clk,
  ddr_memory_if.slave mem
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rsp_q;
  logic [DATA_WIDTH-1:0] ram [MEM_SIZE];

  logic                  capture;
  logic                  ram_we;
  logic                  rd_en;
  logic                  in_range;

  assign in_range = (32'(addr_q) < MEM_SIZE);

  always_ff @(posedge clk or negedge mem.reset) begin
    if (!mem.reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Simultaneous wr/rd is an illegal command and is dropped in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem.wr && !mem.rd)      state_d = WRITE;
        else if (mem.rd && !mem.wr) state_d = READ;
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    ram_we  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE:    capture = (mem.wr ^ mem.rd);
      WRITE:   ram_we  = in_range;
      READ:    rd_en   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge mem.reset) begin
    if (!mem.reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
      for (int unsigned i = 0; i < MEM_SIZE; i++) ram[i] <= '0;
    end else begin
      rsp_q <= (state_q == WRITE) || (state_q == READ);
      if (capture) begin
        addr_q  <= mem.addr;
        wdata_q <= mem.wdata;
      end
      if (ram_we) ram[addr_q] <= wdata_q;
      if (rd_en)  rdata_q <= in_range ? ram[addr_q] : '0;
    end
  end

  assign mem.rdata   = rdata_q;
  assign mem.slv_rsp = rsp_q;

endmodule

// File: tb/tb_ddr_memory.sv
// Directed self-checking bench for ddr_memory (full-size and a 12-word variant).
module tb_ddr_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  ddr_memory_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus   ();
  ddr_memory_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_s ();

  ddr_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16)) dut (
    .clk(clk), .mem(bus)
  );
  ddr_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(12)) dut_s (
    .clk(clk), .mem(bus_s)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        exp_rsp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit s, bit w, bit r, logic [3:0] a, logic [31:0] d);
    if (s) begin
      bus_s.wr = w; bus_s.rd = r; bus_s.addr = a; bus_s.wdata = d;
    end else begin
      bus.wr = w; bus.rd = r; bus.addr = a; bus.wdata = d;
    end
  endtask

  function automatic logic [31:0] rdata_of(bit s);
    return s ? bus_s.rdata : bus.rdata;
  endfunction

  function automatic logic [31:0] rsp_of(bit s);
    return s ? 32'(bus_s.slv_rsp) : 32'(bus.slv_rsp);
  endfunction

  // One command: sampled at edge N, response/rdata checked after edge N+1.
  task automatic op(bit s, bit w, bit r, logic [3:0] a, logic [31:0] d,
                    logic exp_rsp, logic [31:0] exp_rd, string nm);
    @(negedge clk);
    drive(s, w, r, a, d);
    @(posedge clk);
    #1 drive(s, 1'b0, 1'b0, 4'd0, 32'd0);
    chk({nm, "_busy_rsp"}, rsp_of(s), 32'd0);
    @(posedge clk);
    #1;
    chk({nm, "_rsp"}, rsp_of(s), 32'(exp_rsp));
    chk({nm, "_rdata"}, rdata_of(s), exp_rd);
  endtask

  initial begin
    int pulses;

    vecs[0] = '{1'b0, 1'b1, 4'd0,  32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 4'd3,  32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b1, 4'd3,  32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b1, 4'd5,  32'h0000_0055, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 4'd5,  32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 4'd15, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000};
    vecs[6] = '{1'b0, 1'b1, 4'd15, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5};
    vecs[7] = '{1'b1, 1'b0, 4'd3,  32'h1234_5678, 1'b1, 32'hA5A5_A5A5};
    vecs[8] = '{1'b0, 1'b1, 4'd3,  32'h0000_0000, 1'b1, 32'h1234_5678};
    vecs[9] = '{1'b0, 1'b0, 4'd7,  32'hFFFF_FFFF, 1'b0, 32'h1234_5678};

    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    bus.reset   = 1'b0;
    bus_s.reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_rsp", 32'(bus.slv_rsp), 32'd0);
    @(negedge clk);
    bus.reset   = 1'b1;
    bus_s.reset = 1'b1;

    for (int i = 0; i < 16; i++)
      op(1'b0, 1'b0, 1'b1, 4'(i), 32'd0, 1'b1, 32'd0, $sformatf("rst_rd%0d", i));

    for (int i = 0; i < 10; i++)
      op(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
         vecs[i].exp_rsp, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++)
      op(1'b0, 1'b1, 1'b0, 4'(i), 32'h1000_0000 + 32'(i), 1'b1, 32'h1234_5678,
         $sformatf("sweep_wr%0d", i));
    for (int i = 0; i < 16; i++)
      op(1'b0, 1'b0, 1'b1, 4'(i), 32'd0, 1'b1, 32'h1000_0000 + 32'(i),
         $sformatf("sweep_rd%0d", i));

    // Held write: accepted every other edge, so pulses alternate 0,1,0,1,0,1.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'd7, 32'h0000_0077);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.slv_rsp) pulses++;
      chk($sformatf("held_rsp%0d", k), 32'(bus.slv_rsp), 32'(k % 2));
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("held_pulses", 32'(pulses), 32'd3);
    op(1'b0, 1'b0, 1'b1, 4'd7, 32'd0, 1'b1, 32'h0000_0077, "held_readback");

    op(1'b1, 1'b1, 1'b0, 4'd13, 32'h0000_CAFE, 1'b1, 32'd0, "oor_wr13");
    op(1'b1, 1'b1, 1'b0, 4'd11, 32'h0000_BEEF, 1'b1, 32'd0, "small_wr11");
    op(1'b1, 1'b0, 1'b1, 4'd11, 32'd0, 1'b1, 32'h0000_BEEF, "small_rd11");
    op(1'b1, 1'b0, 1'b1, 4'd13, 32'd0, 1'b1, 32'd0, "oor_rd13");
    op(1'b1, 1'b0, 1'b1, 4'd11, 32'd0, 1'b1, 32'h0000_BEEF, "small_rd11b");
    op(1'b1, 1'b0, 1'b1, 4'd1,  32'd0, 1'b1, 32'd0, "small_rd1_alias");

    // Reset while the read response is high: outputs clear without a clock edge.
    op(1'b0, 1'b1, 1'b0, 4'd9, 32'h9999_0009, 1'b1, 32'h0000_0077, "pre_wr9");
    op(1'b0, 1'b0, 1'b1, 4'd9, 32'd0, 1'b1, 32'h9999_0009, "pre_rd9");
    #2 bus.reset = 1'b0;
    #1;
    chk("async_rst_rsp", 32'(bus.slv_rsp), 32'd0);
    chk("async_rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    bus.reset = 1'b1;
    op(1'b0, 1'b0, 1'b1, 4'd9, 32'd0, 1'b1, 32'd0, "post_rst_rd9");

    // Reset inside the READ state abandons the command.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 32'd0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    bus.reset = 1'b0;
    #1;
    chk("rd_state_rst_rsp", 32'(bus.slv_rsp), 32'd0);
    @(posedge clk);
    #1;
    chk("abandoned_rsp", 32'(bus.slv_rsp), 32'd0);
    chk("abandoned_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    bus.reset = 1'b1;
    op(1'b0, 1'b0, 1'b1, 4'd3, 32'd0, 1'b1, 32'd0, "post_rst_rd3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_memory.md
# ddr_memory

Parameterized single-port word-addressable memory with a simple write/read command interface and a one-bit completion response. It is the memory model exercised by the DDR verification environment: a stimulus agent drives `wr`/`rd`/`addr`/`wdata` through the memory interface and checks `rdata` and `response`. Every accepted command completes in a fixed number of cycles, so the bench can run a scoreboard without a timeout.

## Interface
- `ADDR_WIDTH`, default 4: address bus width.
- `DATA_WIDTH`, default 32: data word width.
- `MEM_SIZE`, default 16: number of words. Must satisfy `MEM_SIZE <= 2**ADDR_WIDTH`.

One clock; reset is asynchronous and active-low.

- `clk`, input, 1: clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `wr`, input, 1: write request.
- `rd`, input, 1: read request.
- `addr`, input, ADDR_WIDTH: word address.
- `wdata`, input, DATA_WIDTH: write data.
- `rdata`, output, DATA_WIDTH: read data.
- `response`, output, 1: completion pulse.

## Operation
- **Reset** (`reset`=0):
  - All memory words clear to 0.
  - `rdata`=0 and `response`=0.
  - FSM goes to IDLE.
  - Takes effect immediately, not on a clock edge.
- **FSM states:** IDLE, WRITE, READ.
- **IDLE:**
  - `wr`=1 and `rd`=0: capture `addr`/`wdata`, go to WRITE.
  - `rd`=1 and `wr`=0: capture `addr`, go to READ.
  - `wr`=`rd`=0, or `wr`=`rd`=1: stay in IDLE, no memory access, no response. Simultaneous requests are an illegal command and are dropped silently.
- **WRITE:**
  - If captured addr < MEM_SIZE: `mem[addr] <= wdata`.
  - Assert `response` for 1 cycle.
  - Return to IDLE.
- **READ:**
  - `rdata` = `mem[addr]` if addr < MEM_SIZE, else 0.
  - Assert `response` for 1 cycle.
  - Return to IDLE.
- **Out-of-range addresses** (addr >= MEM_SIZE): writes are discarded and reads return 0. Both still complete with a response.
- **Commands during WRITE/READ:** `wr`/`rd` are ignored. The master must hold off or re-issue after `response`.
- **`rdata` hold rule:** `rdata` keeps the last read value until the next read completes or reset. Writes never change `rdata`.
- **No width conversion:** full-word accesses only; no byte enables.

## Timing
- **Command sampling:** on rising edge N while in IDLE.
- **Completion:** `response`=1 during cycle N+1 (registered, set at edge N+1, cleared at edge N+2).
- **Write visibility:** a write updates memory at edge N+1. A read issued at edge N+2 returns the new data.
- **Read latency:** `rdata` is valid from edge N+1, coincident with `response`.
- **Throughput:** at most one command per 2 cycles.
- **Back-to-back:** a command held high continuously is re-accepted at edge N+2.
- **Reset mid-operation:** the pending command is abandoned, `response` drops to 0 immediately, and memory is cleared.
- **Leaving reset:** the first command is sampled at the first rising edge with `reset`=1.

## Structure
- **Shared package `ddr_mem_pkg`:**
  - FSM state enum: IDLE, WRITE, READ.
  - Default parameter constants: 4/32/16.
- **Single module, no sub-modules.**
  - Memory array as a `DATA_WIDTH` x `MEM_SIZE` register array with async clear.
  - Separate address/data capture registers.
- **Memory interface bundle:** carries `reset`, `wr`, `rd`, `addr`, `wdata`, `rdata`, `slv_rsp`. `slv_rsp` connects to `response`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then read addresses 0..15 → each returns 0 with one `response` pulse; `rdata` and `response` are 0 during reset.
- **Write/readback:** write 0xDEADBEEF to addr 3, then read addr 3 → `response` pulses after each command; `rdata`=0xDEADBEEF one cycle after read sampling.
- **Full sweep:** write addr i with 0x1000_0000+i for i=0..15, then read all → every value matches; no aliasing between words.
- **Illegal command:** `wr`=`rd`=1 at addr 5 with `wdata`=0x55 → no `response`; a later read of addr 5 still returns the prior value (0 after reset).
- **Held request:** hold `wr`=1 for 6 cycles → exactly 3 `response` pulses on alternate cycles.
- **Reset during READ:** assert `reset`=0 in the READ cycle → `response` and `rdata` drop to 0 asynchronously; a subsequent read of a previously written address returns 0.
